// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data access.
// Tracks the single outstanding read and returns its data to the requester that issued it.
module riscv_mem_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_imem_req,
  input  logic [XLEN-1:0] i_imem_addr,
  output logic            o_imem_gnt,
  output logic            o_imem_rvalid,
  output logic [XLEN-1:0] o_imem_rd_data,
  input  logic            i_dmem_req,
  input  logic            i_dmem_wr_en,
  input  logic [XLEN-1:0] i_dmem_addr,
  input  logic [3:0]      i_dmem_byte_sel,
  input  logic [XLEN-1:0] i_dmem_wr_data,
  output logic            o_dmem_gnt,
  output logic            o_dmem_rvalid,
  output logic [XLEN-1:0] o_dmem_rd_data,
  output logic            o_mem_req,
  output logic            o_mem_wr_en,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_byte_sel,
  output logic [XLEN-1:0] o_mem_wr_data,
  input  logic [XLEN-1:0] i_mem_rd_data
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  localparam logic       SelImem = 1'b0;
  localparam logic       SelDmem = 1'b1;
  localparam logic [2:0] LatInit = 3'(RD_LATENCY - 1);

  state_e     state_q, state_d;
  logic [2:0] lat_cnt_q, lat_cnt_d;
  logic       owner_q, owner_d;
  logic       last_gnt_q, last_gnt_d;

  logic rd_done;
  logic can_grant;
  logic gnt_imem;
  logic gnt_dmem;

  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    owner_d        = owner_q;
    last_gnt_d     = last_gnt_q;
    o_imem_gnt     = 1'b0;
    o_imem_rvalid  = 1'b0;
    o_imem_rd_data = '0;
    o_dmem_gnt     = 1'b0;
    o_dmem_rvalid  = 1'b0;
    o_dmem_rd_data = '0;
    o_mem_req      = 1'b0;
    o_mem_wr_en    = 1'b0;
    o_mem_addr     = '0;
    o_mem_byte_sel = '0;
    o_mem_wr_data  = '0;

    // Reset gates everything so a read in flight never produces a late rvalid.
    rd_done   = !i_rst && (state_q == StRdWait) && (lat_cnt_q == 3'd0);
    can_grant = !i_rst && ((state_q == StIdle) || rd_done);
    gnt_imem  = can_grant && i_imem_req && (!i_dmem_req || (last_gnt_q == SelDmem));
    gnt_dmem  = can_grant && i_dmem_req && !gnt_imem;

    if (rd_done) begin
      state_d = StIdle;
      if (owner_q == SelDmem) begin
        o_dmem_rvalid  = 1'b1;
        o_dmem_rd_data = i_mem_rd_data;
      end else begin
        o_imem_rvalid  = 1'b1;
        o_imem_rd_data = i_mem_rd_data;
      end
    end else if (state_q == StRdWait) begin
      lat_cnt_d = lat_cnt_q - 3'd1;
    end

    if (gnt_imem) begin
      o_imem_gnt     = 1'b1;
      o_mem_req      = 1'b1;
      o_mem_addr     = i_imem_addr;
      o_mem_byte_sel = 4'b1111;
      last_gnt_d     = SelImem;
      owner_d        = SelImem;
      lat_cnt_d      = LatInit;
      state_d        = StRdWait;
    end else if (gnt_dmem) begin
      o_dmem_gnt     = 1'b1;
      o_mem_req      = 1'b1;
      o_mem_wr_en    = i_dmem_wr_en;
      o_mem_addr     = i_dmem_addr;
      o_mem_byte_sel = i_dmem_byte_sel;
      o_mem_wr_data  = i_dmem_wr_data;
      last_gnt_d     = SelDmem;
      if (!i_dmem_wr_en) begin
        owner_d   = SelDmem;
        lat_cnt_d = LatInit;
        state_d   = StRdWait;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      lat_cnt_q  <= 3'd0;
      owner_q    <= SelImem;
      last_gnt_q <= SelDmem;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: one instance at read latency 2, one at latency 3
// for the reset-during-read case. Both share the same stimulus.
module tb_riscv_mem_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            dmem_req;
  logic            dmem_wr_en;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_byte_sel;
  logic [XLEN-1:0] dmem_wr_data;
  logic [XLEN-1:0] mem_rd_data;

  logic            imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid;
  logic [XLEN-1:0] imem_rd_data, dmem_rd_data;
  logic            mem_req, mem_wr_en;
  logic [XLEN-1:0] mem_addr, mem_wr_data;
  logic [3:0]      mem_byte_sel;

  logic            imem_gnt3, imem_rvalid3, dmem_gnt3, dmem_rvalid3;
  logic [XLEN-1:0] imem_rd_data3, dmem_rd_data3;
  logic            mem_req3, mem_wr_en3;
  logic [XLEN-1:0] mem_addr3, mem_wr_data3;
  logic [3:0]      mem_byte_sel3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.XLEN(XLEN), .RD_LATENCY(2)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_imem_req(imem_req), .i_imem_addr(imem_addr),
    .o_imem_gnt(imem_gnt), .o_imem_rvalid(imem_rvalid), .o_imem_rd_data(imem_rd_data),
    .i_dmem_req(dmem_req), .i_dmem_wr_en(dmem_wr_en), .i_dmem_addr(dmem_addr),
    .i_dmem_byte_sel(dmem_byte_sel), .i_dmem_wr_data(dmem_wr_data),
    .o_dmem_gnt(dmem_gnt), .o_dmem_rvalid(dmem_rvalid), .o_dmem_rd_data(dmem_rd_data),
    .o_mem_req(mem_req), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_byte_sel(mem_byte_sel), .o_mem_wr_data(mem_wr_data), .i_mem_rd_data(mem_rd_data)
  );

  riscv_mem_arbiter #(.XLEN(XLEN), .RD_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_imem_req(imem_req), .i_imem_addr(imem_addr),
    .o_imem_gnt(imem_gnt3), .o_imem_rvalid(imem_rvalid3), .o_imem_rd_data(imem_rd_data3),
    .i_dmem_req(dmem_req), .i_dmem_wr_en(dmem_wr_en), .i_dmem_addr(dmem_addr),
    .i_dmem_byte_sel(dmem_byte_sel), .i_dmem_wr_data(dmem_wr_data),
    .o_dmem_gnt(dmem_gnt3), .o_dmem_rvalid(dmem_rvalid3), .o_dmem_rd_data(dmem_rd_data3),
    .o_mem_req(mem_req3), .o_mem_wr_en(mem_wr_en3), .o_mem_addr(mem_addr3),
    .o_mem_byte_sel(mem_byte_sel3), .o_mem_wr_data(mem_wr_data3), .i_mem_rd_data(mem_rd_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    rst           = 1'b0;
    imem_req      = 1'b0;
    imem_addr     = '0;
    dmem_req      = 1'b0;
    dmem_wr_en    = 1'b0;
    dmem_addr     = '0;
    dmem_byte_sel = '0;
    dmem_wr_data  = '0;
    mem_rd_data   = '0;
  endtask

  initial begin
    idle_inputs();

    // Reset held two cycles with both requesters active.
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      rst          = 1'b1;
      imem_req     = 1'b1;
      imem_addr    = 32'h0000_0040;
      dmem_req     = 1'b1;
      dmem_addr    = 32'h0000_0080;
      dmem_wr_data = 32'h1111_2222;
      dmem_byte_sel = 4'b1111;
      mem_rd_data  = 32'hAAAA_5555;
      settle();
      check_eq("rst_imem_gnt", {31'd0, imem_gnt}, 32'd0);
      check_eq("rst_dmem_gnt", {31'd0, dmem_gnt}, 32'd0);
      check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      check_eq("rst_mem_wdata", mem_wr_data, 32'd0);
      check_eq("rst_rvalid", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
      check_eq("rst_rd_data", imem_rd_data | dmem_rd_data, 32'd0);
    end
    next_cycle();
    idle_inputs();

    // Lone fetch, latency 2.
    next_cycle();
    imem_req  = 1'b1;
    imem_addr = 32'h0000_0100;
    settle();
    check_eq("fetch_gnt", {31'd0, imem_gnt}, 32'd1);
    check_eq("fetch_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("fetch_mem_addr", mem_addr, 32'h0000_0100);
    check_eq("fetch_byte_sel", {28'd0, mem_byte_sel}, 32'hF);
    check_eq("fetch_wr_en", {31'd0, mem_wr_en}, 32'd0);
    next_cycle();
    imem_req = 1'b0;
    settle();
    check_eq("fetch_t1_rvalid", {31'd0, imem_rvalid}, 32'd0);
    check_eq("fetch_t1_mem_req", {31'd0, mem_req}, 32'd0);
    next_cycle();
    mem_rd_data = 32'h1234_5678;
    settle();
    check_eq("fetch_t2_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check_eq("fetch_t2_data", imem_rd_data, 32'h1234_5678);
    check_eq("fetch_t2_dmem_data", dmem_rd_data, 32'd0);
    check_eq("fetch_t2_dmem_rvalid", {31'd0, dmem_rvalid}, 32'd0);
    next_cycle();
    mem_rd_data = '0;
    settle();
    check_eq("fetch_t3_rvalid", {31'd0, imem_rvalid}, 32'd0);

    // Contention after reset: IMEM first, then alternating; read completion and the
    // next grant share a cycle.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst       = 1'b0;
    imem_req  = 1'b1;
    imem_addr = 32'h0000_0200;
    dmem_req  = 1'b1;
    dmem_addr = 32'h0000_3000;
    for (int c = 0; c < 9; c++) begin
      if (c == 7) begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
      end
      mem_rd_data = 32'hC0DE_0000 + 32'(c);
      settle();
      check_eq($sformatf("rr_imem_gnt_c%0d", c), {31'd0, imem_gnt},
               {31'd0, (c == 0 || c == 4)});
      check_eq($sformatf("rr_dmem_gnt_c%0d", c), {31'd0, dmem_gnt},
               {31'd0, (c == 2 || c == 6)});
      check_eq($sformatf("rr_imem_rvalid_c%0d", c), {31'd0, imem_rvalid},
               {31'd0, (c == 2 || c == 6)});
      check_eq($sformatf("rr_dmem_rvalid_c%0d", c), {31'd0, dmem_rvalid},
               {31'd0, (c == 4 || c == 8)});
      if (c == 2) check_eq("rr_c2_imem_data", imem_rd_data, 32'hC0DE_0002);
      if (c == 2) check_eq("rr_c2_mem_addr", mem_addr, 32'h0000_3000);
      if (c == 4) check_eq("rr_c4_dmem_data", dmem_rd_data, 32'hC0DE_0004);
      if (c == 4) check_eq("rr_c4_imem_data", imem_rd_data, 32'd0);
      next_cycle();
    end
    idle_inputs();

    // Data writes: granted with write enable, no rvalid, back-to-back every cycle.
    dmem_req      = 1'b1;
    dmem_wr_en    = 1'b1;
    dmem_addr     = 32'h0000_2004;
    dmem_byte_sel = 4'b0011;
    dmem_wr_data  = 32'hDEAD_BEEF;
    settle();
    check_eq("wr_gnt", {31'd0, dmem_gnt}, 32'd1);
    check_eq("wr_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("wr_en", {31'd0, mem_wr_en}, 32'd1);
    check_eq("wr_addr", mem_addr, 32'h0000_2004);
    check_eq("wr_data", mem_wr_data, 32'hDEAD_BEEF);
    check_eq("wr_byte_sel", {28'd0, mem_byte_sel}, 32'h3);
    next_cycle();
    dmem_addr    = 32'h0000_2008;
    dmem_wr_data = 32'h0BAD_F00D;
    settle();
    check_eq("wr2_gnt", {31'd0, dmem_gnt}, 32'd1);
    check_eq("wr2_addr", mem_addr, 32'h0000_2008);
    check_eq("wr2_rvalid", {31'd0, dmem_rvalid}, 32'd0);
    next_cycle();
    idle_inputs();
    mem_rd_data = 32'h5A5A_5A5A;
    for (int c = 0; c < 2; c++) begin
      settle();
      check_eq($sformatf("wr_no_rvalid_%0d", c), {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
      next_cycle();
    end

    // Reset one cycle into a latency-3 read drops the pending rvalid.
    rst = 1'b1;
    next_cycle();
    idle_inputs();
    next_cycle();
    imem_req  = 1'b1;
    imem_addr = 32'h0000_0300;
    settle();
    check_eq("rstrd_gnt", {31'd0, imem_gnt3}, 32'd1);
    check_eq("rstrd_addr", mem_addr3, 32'h0000_0300);
    next_cycle();
    imem_req = 1'b0;
    rst      = 1'b1;
    settle();
    check_eq("rstrd_t1_mem_req", {31'd0, mem_req3}, 32'd0);
    next_cycle();
    rst = 1'b0;
    settle();
    check_eq("rstrd_t2_rvalid", {31'd0, imem_rvalid3}, 32'd0);
    next_cycle();
    mem_rd_data = 32'hFEED_FACE;
    dmem_req    = 1'b1;
    dmem_addr   = 32'h0000_4000;
    settle();
    check_eq("rstrd_t3_rvalid", {31'd0, imem_rvalid3}, 32'd0);
    check_eq("rstrd_t3_data", imem_rd_data3, 32'd0);
    check_eq("rstrd_t3_dmem_gnt", {31'd0, dmem_gnt3}, 32'd1);
    check_eq("rstrd_t3_mem_addr", mem_addr3, 32'h0000_4000);
    next_cycle();
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
